ext_sram_arbiter: RTL and testbench
===================================

Name: ext_sram_arbiter

Overview:
- Shares the single external SRAM adapter port (ram_addr/ram_cen/ram_wen/ram_din/ram_dout) between two masters.
- Master 1 is the openMSP430 data-memory port, which has priority. Master 2 is a secondary DMA/video master using a req/gnt handshake.
- Sits between the core/DMA and the SRAM adapter.
- Guarantees DMA forward progress with a starvation counter that stalls the CPU for one access.
- Routes each read's return data back to the master that issued it.

Parameters:
- ADDR_WIDTH, 9, word-address width shared by both masters and the adapter.
- STARVE_MAX, 8, number of consecutive denied DMA-request cycles before a forced DMA grant; legal range 1..255.

Ports:
- clk  in  1  core clock; adapter uses both edges, arbiter uses posedge only.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_cen  in  1  CPU chip enable, active-low.
- cpu_wen  in  2  CPU byte write enables, active-low; 2'b11 means read.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  CPU read data.
- cpu_wait  out  1  CPU access not performed this cycle; CPU holds its request.
- dma_req  in  1  DMA access request, held until granted.
- dma_addr  in  ADDR_WIDTH  DMA word address.
- dma_wen  in  2  DMA byte write enables, active-low; 2'b11 means read.
- dma_din  in  16  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_dout  out  16  DMA read data.
- dma_rvalid  out  1  dma_dout valid pulse.
- ram_addr  out  ADDR_WIDTH  to adapter.
- ram_cen  out  1  to adapter.
- ram_wen  out  2  to adapter.
- ram_din  out  16  to adapter.
- ram_dout  in  16  from adapter; valid in the cycle after a read.

Behaviour:
- Request definitions: cpu_act = !cpu_cen; dma_act = dma_req.
- Grant (combinational, same cycle; the adapter samples at the following negedge):
  - If force_q=1: DMA wins whenever dma_act.
  - Otherwise: CPU wins whenever cpu_act; DMA wins only when dma_act && !cpu_act.
- Output signals:
  - dma_gnt = DMA wins.
  - cpu_wait = cpu_act && DMA wins.
- Adapter mux:
  - The winner drives ram_addr, ram_wen and ram_din; ram_cen=0.
  - With no winner: ram_cen=1, ram_wen=2'b11, and ram_addr/ram_din hold the CPU values.
- Starvation counter starve_q (posedge):
  - Cleared on dma_gnt or when !dma_req.
  - Incremented when dma_req && !dma_gnt.
  - When it increments to STARVE_MAX, force_q is set for the next cycle.
  - force_q clears after any cycle in which it was 1.
  - If dma_req drops while forced, force_q still clears and the CPU is not stalled.
- Read return, registered rd_own_q in {NONE, CPU, DMA}:
  - Set to the winner when that access is a read (wen==2'b11); otherwise NONE.
- cpu_dout:
  - Equals ram_dout when rd_own_q==CPU; otherwise holds cpu_hold_q.
  - cpu_hold_q captures ram_dout whenever rd_own_q==CPU.
  - Result: the last CPU read is held across DMA cycles.
- dma_dout and dma_rvalid:
  - dma_dout is the same scheme with dma_hold_q.
  - dma_rvalid = (rd_own_q==DMA).
- Latency: read data returns one cycle after grant for both masters, matching the core's single-cycle RAM model.
- Writes: no return traffic; rd_own_q=NONE.
- Back-to-back accesses alternating between masters are allowed every cycle.
- Reset (asynchronous, any time, including mid-access):
  - starve_q=0, force_q=0, rd_own_q=NONE, cpu_hold_q=0, dma_hold_q=0.
  - Therefore cpu_dout=0, dma_dout=0, dma_rvalid=0.
  - Combinational outputs follow their inputs.
  - A read in flight at reset is dropped; no rvalid is issued.
- Width rules:
  - starve_q is 8 bits.
  - Comparison against STARVE_MAX is unsigned.
  - The counter saturates; it never wraps.

Decomposition:
- Package ext_sram_arb_pkg:
  - Owner encoding: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2.
  - STARVE_W=8.
  - WEN_READ=2'b11.
- Sub-module ext_sram_starve_ctr: contains starve_q and force_q.
  - Inputs: dma_req, dma_gnt.
  - Output: force.
- Grant mux and read-return logic stay in the top module.

Test Plan:
- CPU-only: reset, CPU read at addr 0x010 while the adapter model returns 0xBEEF the next cycle -> cpu_dout=0xBEEF one cycle after grant; dma_gnt=0 and cpu_wait=0 throughout.
- DMA idle-slot access: cpu_cen=1, dma_req with a read at 0x1FF (model data 0x1234) -> dma_gnt=1 the same cycle; dma_rvalid=1 with dma_dout=0x1234 the next cycle; cpu_dout unchanged.
- Starvation with STARVE_MAX=8: CPU reads every cycle while dma_req is held -> denied for 8 cycles, then on cycle 9 cpu_wait=1 and dma_gnt=1; cycle 10 returns to the CPU and starve_q=0.
- Interleave hold: CPU reads 0xAAAA, then a DMA read returns 0x5555 -> cpu_dout stays 0xAAAA while dma_dout=0x5555.
- Byte write: DMA write with wen=2'b01, din=0x00CC -> ram_wen=2'b01 and ram_din=0x00CC; dma_rvalid stays 0 the next cycle.
- Reset mid-read: assert reset_n=0 in the cycle after a DMA read grant -> dma_rvalid=0 and dma_dout=0; after release, the first access behaves normally.

Source files
------------

// File: rtl/ext_sram_arb_pkg.sv
// rtl/ext_sram_arb_pkg.sv - shared types and constants for the external SRAM arbiter
package ext_sram_arb_pkg;

  localparam int STARVE_W = 8;
  localparam logic [1:0] WEN_READ = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } own_e;

endpackage

// File: rtl/ext_sram_starve_ctr.sv
// rtl/ext_sram_starve_ctr.sv - DMA starvation counter; raises a one-cycle forced DMA grant
module ext_sram_starve_ctr
  import ext_sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_grant
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                force_q, force_d;

  // force_d is only raised on the increment that lands on the limit, so it
  // lasts exactly one cycle; the counter saturates instead of wrapping.
  always_comb begin
    starve_d = starve_q;
    force_d  = 1'b0;
    if (dma_gnt || !dma_req) begin
      starve_d = '0;
    end else if (starve_q != '1) begin
      starve_d = starve_q + STARVE_W'(1);
      force_d  = (starve_d == STARVE_LIM);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      force_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      force_q  <= force_d;
    end
  end

  assign force_grant = force_q;

endmodule

// File: rtl/ext_sram_arbiter.sv
// rtl/ext_sram_arbiter.sv - shares one SRAM adapter port between the CPU (priority) and a DMA master
module ext_sram_arbiter
  import ext_sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_cen,
  input  logic [1:0]            cpu_wen,
  input  logic [15:0]           cpu_din,
  output logic [15:0]           cpu_dout,
  output logic                  cpu_wait,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [1:0]            dma_wen,
  input  logic [15:0]           dma_din,
  output logic                  dma_gnt,
  output logic [15:0]           dma_dout,
  output logic                  dma_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cen,
  output logic [1:0]            ram_wen,
  output logic [15:0]           ram_din,
  input  logic [15:0]           ram_dout
);

  logic  cpu_act, dma_act, cpu_win, dma_win, force_grant;
  own_e  rd_own_q, rd_own_d;
  logic [15:0] cpu_hold_q, cpu_hold_d, dma_hold_q, dma_hold_d;

  ext_sram_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset_n    (reset_n),
    .dma_req    (dma_req),
    .dma_gnt    (dma_win),
    .force_grant(force_grant)
  );

  assign cpu_act = !cpu_cen;
  assign dma_act = dma_req;
  assign dma_win = dma_act && (force_grant || !cpu_act);
  assign cpu_win = cpu_act && !dma_win;

  assign dma_gnt  = dma_win;
  assign cpu_wait = cpu_act && dma_win;

  // Idle cycles keep the CPU address/data on the bus so the adapter sees no toggling.
  assign ram_cen  = !(cpu_win || dma_win);
  assign ram_addr = dma_win ? dma_addr : cpu_addr;
  assign ram_din  = dma_win ? dma_din  : cpu_din;
  assign ram_wen  = dma_win ? dma_wen  : (cpu_win ? cpu_wen : WEN_READ);

  always_comb begin
    rd_own_d = OWN_NONE;
    if (cpu_win && (cpu_wen == WEN_READ)) begin
      rd_own_d = OWN_CPU;
    end else if (dma_win && (dma_wen == WEN_READ)) begin
      rd_own_d = OWN_DMA;
    end
  end

  always_comb begin
    cpu_hold_d = (rd_own_q == OWN_CPU) ? ram_dout : cpu_hold_q;
    dma_hold_d = (rd_own_q == OWN_DMA) ? ram_dout : dma_hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_own_q   <= OWN_NONE;
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      rd_own_q   <= rd_own_d;
      cpu_hold_q <= cpu_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

  assign cpu_dout   = cpu_hold_d;
  assign dma_dout   = dma_hold_d;
  assign dma_rvalid = (rd_own_q == OWN_DMA);

endmodule

// File: tb/tb_ext_sram_arbiter.sv
// tb/tb_ext_sram_arbiter.sv - scoreboard bench for ext_sram_arbiter with a behavioural SRAM adapter
module tb_ext_sram_arbiter;

  localparam int AW = 9;
  localparam int W_NONE = 0;
  localparam int W_CPU  = 1;
  localparam int W_DMA  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_cen = 1'b1;
  logic [1:0]    cpu_wen = 2'b11;
  logic [15:0]   cpu_din = '0;
  logic [15:0]   cpu_dout;
  logic          cpu_wait;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [1:0]    dma_wen = 2'b11;
  logic [15:0]   dma_din = '0;
  logic          dma_gnt;
  logic [15:0]   dma_dout;
  logic          dma_rvalid;
  logic [AW-1:0] ram_addr;
  logic          ram_cen;
  logic [1:0]    ram_wen;
  logic [15:0]   ram_din;
  logic [15:0]   ram_dout = '0;

  ext_sram_arbiter #(.ADDR_WIDTH(AW), .STARVE_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wen(dma_wen), .dma_din(dma_din),
    .dma_gnt(dma_gnt), .dma_dout(dma_dout), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!ram_cen) begin
      if (ram_wen == 2'b11) begin
        ram_dout <= mem[ram_addr];
      end else begin
        if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
        if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      end
    end
  end

  typedef struct {
    int          own;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cpu = '0;
  logic [15:0] exp_dma = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic issue(input string tag, input int win,
                       input logic ccen, input logic [AW-1:0] caddr, input logic [1:0] cwen,
                       input logic [15:0] cdin, input logic dreq, input logic [AW-1:0] daddr,
                       input logic [1:0] dwen, input logic [15:0] ddin);
    exp_t e;
    cpu_cen = ccen; cpu_addr = caddr; cpu_wen = cwen; cpu_din = cdin;
    dma_req = dreq; dma_addr = daddr; dma_wen = dwen; dma_din = ddin;
    #1;
    chk({tag, ".dma_gnt"}, 32'(dma_gnt), 32'(win == W_DMA));
    chk({tag, ".cpu_wait"}, 32'(cpu_wait), 32'((win == W_DMA) && !ccen));
    chk({tag, ".ram_cen"}, 32'(ram_cen), 32'(win == W_NONE));
    e.own = W_NONE;
    e.data = '0;
    if (win == W_DMA) begin
      chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(daddr));
      chk({tag, ".ram_wen"}, 32'(ram_wen), 32'(dwen));
      chk({tag, ".ram_din"}, 32'(ram_din), 32'(ddin));
      if (dwen == 2'b11) begin e.own = W_DMA; e.data = mem[daddr]; end
    end else if (win == W_CPU) begin
      chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(caddr));
      chk({tag, ".ram_wen"}, 32'(ram_wen), 32'(cwen));
      chk({tag, ".ram_din"}, 32'(ram_din), 32'(cdin));
      if (cwen == 2'b11) begin e.own = W_CPU; e.data = mem[caddr]; end
    end else begin
      chk({tag, ".ram_wen_idle"}, 32'(ram_wen), 32'h3);
      chk({tag, ".ram_addr_idle"}, 32'(ram_addr), 32'(caddr));
    end
    sb.push_back(e);
  endtask

  task automatic retire(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (e.own == W_CPU) exp_cpu = e.data;
    if (e.own == W_DMA) exp_dma = e.data;
    chk({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'(e.own == W_DMA));
    chk({tag, ".cpu_dout"}, 32'(cpu_dout), 32'(exp_cpu));
    chk({tag, ".dma_dout"}, 32'(dma_dout), 32'(exp_dma));
  endtask

  task automatic drive(input string tag, input int win,
                       input logic ccen, input logic [AW-1:0] caddr, input logic [1:0] cwen,
                       input logic [15:0] cdin, input logic dreq, input logic [AW-1:0] daddr,
                       input logic [1:0] dwen, input logic [15:0] ddin);
    issue(tag, win, ccen, caddr, cwen, cdin, dreq, daddr, dwen, ddin);
    @(posedge clk);
    #1;
    retire(tag);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 257) ^ 16'h5A5A;
    mem[9'h010] = 16'hBEEF;
    mem[9'h1FF] = 16'h1234;
    mem[9'h020] = 16'hAAAA;
    mem[9'h030] = 16'h5555;
    mem[9'h040] = 16'h7777;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.cpu_dout", 32'(cpu_dout), 32'h0);
    chk("rst.dma_dout", 32'(dma_dout), 32'h0);
    chk("rst.dma_rvalid", 32'(dma_rvalid), 32'h0);
    reset_n = 1'b1;

    drive("cpu_rd", W_CPU, 1'b0, 9'h010, 2'b11, 16'h0, 1'b0, 9'h0, 2'b11, 16'h0);
    drive("idle0", W_NONE, 1'b1, 9'h010, 2'b11, 16'h0, 1'b0, 9'h0, 2'b11, 16'h0);
    drive("dma_idle_rd", W_DMA, 1'b1, 9'h010, 2'b11, 16'h0, 1'b1, 9'h1FF, 2'b11, 16'h0);
    drive("idle1", W_NONE, 1'b1, 9'h010, 2'b11, 16'h0, 1'b0, 9'h0, 2'b11, 16'h0);

    drive("il_cpu", W_CPU, 1'b0, 9'h020, 2'b11, 16'h0, 1'b0, 9'h0, 2'b11, 16'h0);
    drive("il_dma", W_DMA, 1'b1, 9'h020, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);
    drive("il_cpu2", W_CPU, 1'b0, 9'h1FF, 2'b11, 16'h0, 1'b1, 9'h010, 2'b11, 16'h0);
    drive("il_dma2", W_DMA, 1'b1, 9'h020, 2'b11, 16'h0, 1'b1, 9'h010, 2'b11, 16'h0);

    drive("bw_dma", W_DMA, 1'b1, 9'h020, 2'b11, 16'h0, 1'b1, 9'h040, 2'b01, 16'h00CC);
    drive("bw_rdbk", W_DMA, 1'b1, 9'h020, 2'b11, 16'h0, 1'b1, 9'h040, 2'b11, 16'h0);
    chk("bw_rdbk.value", 32'(dma_dout), 32'h0077);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++)
        drive($sformatf("starve%0d_deny%0d", r, i), W_CPU,
              1'b0, 9'h020, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);
      drive($sformatf("starve%0d_force", r), W_DMA,
            1'b0, 9'h020, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);
    end
    drive("starve_after", W_CPU, 1'b0, 9'h010, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);
    for (int i = 0; i < 7; i++)
      drive($sformatf("drop_deny%0d", i), W_CPU,
            1'b0, 9'h020, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);
    drive("drop_forced", W_CPU, 1'b0, 9'h010, 2'b11, 16'h0, 1'b0, 9'h030, 2'b11, 16'h0);
    drive("drop_rereq", W_CPU, 1'b0, 9'h020, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);
    drive("idle2", W_NONE, 1'b1, 9'h020, 2'b11, 16'h0, 1'b0, 9'h0, 2'b11, 16'h0);

    issue("rst_mid", W_DMA, 1'b1, 9'h020, 2'b11, 16'h0, 1'b1, 9'h1FF, 2'b11, 16'h0);
    @(posedge clk);
    #1;
    cpu_cen = 1'b1;
    dma_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid.dma_rvalid", 32'(dma_rvalid), 32'h0);
    chk("rst_mid.dma_dout", 32'(dma_dout), 32'h0);
    chk("rst_mid.cpu_dout", 32'(cpu_dout), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_mid.dma_rvalid_hold", 32'(dma_rvalid), 32'h0);
    reset_n = 1'b1;
    sb.delete();
    exp_cpu = '0;
    exp_dma = '0;

    drive("post_rst_cpu", W_CPU, 1'b0, 9'h010, 2'b11, 16'h0, 1'b0, 9'h0, 2'b11, 16'h0);
    drive("post_rst_dma", W_DMA, 1'b1, 9'h010, 2'b11, 16'h0, 1'b1, 9'h030, 2'b11, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
